// File: rtl/trackball_pkg.sv
// trackball_pkg
//   Constants shared by the trackball decoder and the trackball emulator:
//   default counter width, default input filter length and the direction
//   encoding carried on the h_dir / v_dir lines.
`timescale 1ns/1ps
package trackball_pkg;

  localparam int CNT_WIDTH_DEF  = 8;
  localparam int FILTER_LEN_DEF = 4;

  // Encoding of the direction line at a step.
  typedef enum logic {
    DIR_INC = 1'b0,
    DIR_DEC = 1'b1
  } dir_e;

endpackage : trackball_pkg

// File: rtl/trackball_axis.sv
// trackball_axis
//   One trackball axis: 2-FF synchronisers on the step clock and direction,
//   a stability filter on the clock, an arm period after reset, step detect
//   and a wrapping up/down position counter.
//
//   Ports:
//     clk       system clock
//     reset     synchronous active-high reset, re-enters the arm period
//     flip      inverts the count direction
//     clr       clears the position counter (wins over a same-cycle step)
//     step_clk  asynchronous step clock from the trackball
//     step_dir  asynchronous direction line from the trackball
//     count     live position counter
//     step      one-cycle pulse per accepted step-clock toggle
`timescale 1ns/1ps
module trackball_axis
  import trackball_pkg::*;
#(
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF,
  parameter int FILTER_LEN = FILTER_LEN_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flip,
  input  logic                 clr,
  input  logic                 step_clk,
  input  logic                 step_dir,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 step
);

  localparam int ARM_CYCLES = FILTER_LEN + 2;
  localparam int ARM_W      = $clog2(ARM_CYCLES + 1);
  localparam int STAB_W     = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  localparam logic [ARM_W-1:0]  ARM_LAST  = ARM_W'(ARM_CYCLES);
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(FILTER_LEN - 1);

  logic [1:0]        clk_sync;
  logic [1:0]        dir_sync;
  logic [ARM_W-1:0]  arm_cnt;
  logic [STAB_W-1:0] stab_cnt;
  logic              accepted;
  logic              arming;
  dir_e              step_dir_eff;

  // NOTE: every clocked block uses non-blocking assignments so that all
  // registers sample pre-edge values; blocking here would collapse the
  // two synchroniser stages into one.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync <= '0;
      dir_sync <= '0;
    end else begin
      clk_sync <= {clk_sync[0], step_clk};
      dir_sync <= {dir_sync[0], step_dir};
    end
  end

  assign arming = (arm_cnt != ARM_LAST);

  // While arming, the accepted level tracks the synced input so that a
  // level held across reset release is never seen as an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      arm_cnt  <= '0;
      stab_cnt <= '0;
      accepted <= 1'b0;
      step     <= 1'b0;
    end else begin
      step <= 1'b0;
      if (arming) begin
        arm_cnt  <= arm_cnt + ARM_W'(1);
        accepted <= clk_sync[1];
        stab_cnt <= '0;
      end else if (clk_sync[1] == accepted) begin
        // A short glitch ends here: the streak is discarded.
        stab_cnt <= '0;
      end else if (stab_cnt == STAB_LAST) begin
        accepted <= ~accepted;
        stab_cnt <= '0;
        step     <= 1'b1;
      end else begin
        stab_cnt <= stab_cnt + STAB_W'(1);
      end
    end
  end

  assign step_dir_eff = dir_e'(dir_sync[1] ^ flip);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (step) begin
      if (step_dir_eff == DIR_INC) count <= count + CNT_WIDTH'(1);
      else                         count <= count - CNT_WIDTH'(1);
    end
  end

endmodule : trackball_axis

// File: rtl/trackball_decoder.sv
// trackball_decoder
//   Receive side of the trackball link. Two filtered axes feed wrapping
//   position counters; the CPU reads them through an atomic snapshot port
//   that also reports the movement since the previous read.
//
//   Ports:
//     clk, reset     system clock, synchronous active-high reset
//     flip           inverts the count direction on both axes
//     h_clk, h_dir   horizontal step clock / direction (asynchronous)
//     v_clk, v_dir   vertical step clock / direction (asynchronous)
//     clr            clears both live counters
//     rd             one-cycle snapshot request
//     sel            read select: 0 = horizontal, 1 = vertical
//     h_count        live horizontal counter
//     v_count        live vertical counter
//     dout           selected axis snapshot
//     ddelta         selected snapshot minus its previous snapshot (mod 2^W)
//     dout_valid     one-cycle pulse the cycle after rd
`timescale 1ns/1ps
module trackball_decoder
  import trackball_pkg::*;
#(
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF,
  parameter int FILTER_LEN = FILTER_LEN_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flip,
  input  logic                 h_clk,
  input  logic                 h_dir,
  input  logic                 v_clk,
  input  logic                 v_dir,
  input  logic                 clr,
  input  logic                 rd,
  input  logic                 sel,
  output logic [CNT_WIDTH-1:0] h_count,
  output logic [CNT_WIDTH-1:0] v_count,
  output logic [CNT_WIDTH-1:0] dout,
  output logic [CNT_WIDTH-1:0] ddelta,
  output logic                 dout_valid
);

  logic                 h_step;
  logic                 v_step;
  logic                 unused_steps;
  logic [CNT_WIDTH-1:0] snap_h;
  logic [CNT_WIDTH-1:0] snap_v;
  logic [CNT_WIDTH-1:0] prev_h;
  logic [CNT_WIDTH-1:0] prev_v;

  trackball_axis #(
    .CNT_WIDTH  (CNT_WIDTH),
    .FILTER_LEN (FILTER_LEN)
  ) u_axis_h (
    .clk      (clk),
    .reset    (reset),
    .flip     (flip),
    .clr      (clr),
    .step_clk (h_clk),
    .step_dir (h_dir),
    .count    (h_count),
    .step     (h_step)
  );

  trackball_axis #(
    .CNT_WIDTH  (CNT_WIDTH),
    .FILTER_LEN (FILTER_LEN)
  ) u_axis_v (
    .clk      (clk),
    .reset    (reset),
    .flip     (flip),
    .clr      (clr),
    .step_clk (v_clk),
    .step_dir (v_dir),
    .count    (v_count),
    .step     (v_step)
  );

  // The step pulses are for future interrupt hooks; the read port only
  // needs the counters.
  assign unused_steps = h_step ^ v_step;

  // The live counters are sampled pre-update, so a read coinciding with a
  // step or clr returns the value before that change.
  // NOTE: snapshot registers are plain flops, not a memory, so they carry a
  // reset; the first delta after reset is then measured from zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      snap_h     <= '0;
      snap_v     <= '0;
      prev_h     <= '0;
      prev_v     <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= rd;
      if (rd) begin
        prev_h <= snap_h;
        prev_v <= snap_v;
        snap_h <= h_count;
        snap_v <= v_count;
      end
    end
  end

  assign dout   = sel ? snap_v : snap_h;
  assign ddelta = sel ? (snap_v - prev_v) : (snap_h - prev_h);

endmodule : trackball_decoder
